// File: rtl/sram_controller.sv
// -----------------------------------------------------------------------------
// sram_controller
//
// Runs the data-memory accesses of the EX/MEM stage on an external 16-bit
// asynchronous SRAM. A 32-bit load or store is done as two 16-bit halves, low
// half first and then high half. Each half is held for WAIT_CYCLES cycles.
// `ready` stays low for the whole access, which stalls the pipeline.
//
// Parameters
//   ADDR_W       SRAM word address width (16-bit words)
//   WAIT_CYCLES  cycles each half-access is held (2..15)
//   BASE_ADDR    byte address that maps to SRAM word 0
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous reset, active-low
//   rdEn       in   load request
//   wrEn       in   store request (takes priority over rdEn)
//   address    in   32-bit byte address
//   writeData  in   32-bit store data
//   readData   out  load result, held until the next load completes
//   ready      out  1 = pipeline may advance, 0 = stall
//   sramAddr   out  SRAM word address
//   sramDqOut  out  data driven toward the SRAM pad
//   sramDqOe   out  1 = drive sramDqOut onto the pad
//   sramDqIn   in   data returned from the SRAM pad
//   sramWeN    out  SRAM write enable, active-low
//   sramOeN    out  SRAM output enable, active-low
// -----------------------------------------------------------------------------
module sram_controller #(
  parameter int ADDR_W      = 18,
  parameter int WAIT_CYCLES = 4,
  parameter int BASE_ADDR   = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdEn,
  input  logic              wrEn,
  input  logic [31:0]       address,
  input  logic [31:0]       writeData,
  output logic [31:0]       readData,
  output logic              ready,
  output logic [ADDR_W-1:0] sramAddr,
  output logic [15:0]       sramDqOut,
  output logic              sramDqOe,
  input  logic [15:0]       sramDqIn,
  output logic              sramWeN,
  output logic              sramOeN
);

  // 4 bits hold the largest legal WAIT_CYCLES (15).
  localparam int              CNT_W    = 4;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    HIGH,
    DONE
  } stateT;

  stateT             state, stateNext;
  logic [CNT_W-1:0]  counter, counterNext;
  logic              opWrite, opWriteNext;
  logic [ADDR_W-2:0] wordAddr, wordAddrNext;
  logic [31:0]       wrData, wrDataNext;

  logic              req;
  logic              halfDone;
  logic [31:0]       offset;
  logic              unusedOffsetBits;

  // Next values of the pad registers.
  logic [ADDR_W-1:0] sramAddrNext;
  logic [15:0]       sramDqOutNext;
  logic              sramDqOeNext;
  logic              sramWeNNext;
  logic              sramOeNNext;

  assign req      = rdEn | wrEn;
  assign halfDone = (counter == LAST_CNT);

  // The SRAM is addressed in 32-bit words, and each word uses two 16-bit
  // locations. The subtraction is modulo 2^32, so addresses below BASE_ADDR
  // wrap to the top of the SRAM without any error.
  assign offset = address - 32'(BASE_ADDR);
  // The byte-lane bits and the bits above the SRAM size have no effect.
  assign unusedOffsetBits = ^{offset[31:ADDR_W+1], offset[1:0]};

  // ready depends on both state and request. An idle cycle that carries a
  // request already counts as a stall cycle.
  assign ready = ((state == IDLE) && !req) || (state == DONE);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: every flop is updated with a non-blocking assignment. Then all
  // registers sample values from before the edge, whatever order the
  // statements are in.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      counter  <= '0;
      opWrite  <= 1'b0;
      wordAddr <= '0;
      wrData   <= '0;
    end else begin
      state    <= stateNext;
      counter  <= counterNext;
      opWrite  <= opWriteNext;
      wordAddr <= wordAddrNext;
      wrData   <= wrDataNext;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. The request is sampled only in IDLE. After that the
  // access runs to completion, whatever happens on the inputs.
  // ---------------------------------------------------------------------------
  // NOTE: each variable gets a default before the case statement. A path that
  // leaves one unassigned would otherwise infer a latch.
  always_comb begin
    stateNext    = state;
    counterNext  = counter;
    opWriteNext  = opWrite;
    wordAddrNext = wordAddr;
    wrDataNext   = wrData;

    unique case (state)
      IDLE: begin
        if (req) begin
          opWriteNext  = wrEn;
          wordAddrNext = offset[ADDR_W:2];
          wrDataNext   = writeData;
          counterNext  = '0;
          stateNext    = LOW;
        end
      end
      LOW: begin
        if (halfDone) begin
          counterNext = '0;
          stateNext   = HIGH;
        end else begin
          counterNext = counter + CNT_W'(1);
        end
      end
      HIGH: begin
        if (halfDone) begin
          counterNext = '0;
          stateNext   = DONE;
        end else begin
          counterNext = counter + CNT_W'(1);
        end
      end
      DONE: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Pad drive. No combinational path reaches the pads. Each pad register is
  // loaded from the state the controller is about to enter, so its value
  // lines up exactly with that state's cycles.
  // ---------------------------------------------------------------------------
  always_comb begin
    sramAddrNext  = sramAddr;
    sramDqOutNext = sramDqOut;
    sramDqOeNext  = 1'b0;
    sramWeNNext   = 1'b1;
    sramOeNNext   = 1'b1;

    if ((stateNext == LOW) || (stateNext == HIGH)) begin
      sramAddrNext = {wordAddrNext, (stateNext == HIGH)};
      if (opWriteNext) begin
        sramDqOutNext = (stateNext == HIGH) ? wrDataNext[31:16] : wrDataNext[15:0];
        sramDqOeNext  = 1'b1;
        // The last cycle of each half keeps address and data stable while the
        // write strobe is high. This gives hold time on the asynchronous part.
        sramWeNNext   = (counterNext == LAST_CNT);
      end else begin
        sramOeNNext = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sramAddr  <= '0;
      sramDqOut <= '0;
      sramDqOe  <= 1'b0;
      sramWeN   <= 1'b1;
      sramOeN   <= 1'b1;
    end else begin
      sramAddr  <= sramAddrNext;
      sramDqOut <= sramDqOutNext;
      sramDqOe  <= sramDqOeNext;
      sramWeN   <= sramWeNNext;
      sramOeN   <= sramOeNNext;
    end
  end

  // ---------------------------------------------------------------------------
  // Load result. Each half is captured at the end of its final cycle, when the
  // SRAM output has had the whole hold window to settle. A reset during an
  // access discards whatever has been captured so far.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      readData <= '0;
    end else if (!opWrite && halfDone) begin
      if (state == LOW) begin
        readData[15:0] <= sramDqIn;
      end else if (state == HIGH) begin
        readData[31:16] <= sramDqIn;
      end
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
// -----------------------------------------------------------------------------
// tb_sram_controller
//
// Self-checking bench for sram_controller with ADDR_W=18, WAIT_CYCLES=4 and
// BASE_ADDR=1024. A simple SRAM pad model sits behind the controller. Every
// access is checked cycle by cycle against the waveform the access rules
// predict. Load results are compared with a word-level reference memory.
// -----------------------------------------------------------------------------
module tb_sram_controller;

  localparam int W      = 4;
  localparam int ADDR_W = 18;
  localparam int NV     = 11;

  logic              clk;
  logic              rst;
  logic              rdEn;
  logic              wrEn;
  logic [31:0]       address;
  logic [31:0]       writeData;
  logic [31:0]       readData;
  logic              ready;
  logic [ADDR_W-1:0] sramAddr;
  logic [15:0]       sramDqOut;
  logic              sramDqOe;
  logic [15:0]       sramDqIn;
  logic              sramWeN;
  logic              sramOeN;

  sram_controller #(
    .ADDR_W     (ADDR_W),
    .WAIT_CYCLES(W),
    .BASE_ADDR  (1024)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rdEn     (rdEn),
    .wrEn     (wrEn),
    .address  (address),
    .writeData(writeData),
    .readData (readData),
    .ready    (ready),
    .sramAddr (sramAddr),
    .sramDqOut(sramDqOut),
    .sramDqOe (sramDqOe),
    .sramDqIn (sramDqIn),
    .sramWeN  (sramWeN),
    .sramOeN  (sramOeN)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Asynchronous SRAM pad model, plus a preload port used while in reset
  // ---------------------------------------------------------------------------
  bit   [15:0]       padMem [0:(1<<ADDR_W)-1];
  logic              preloadEn;
  logic [ADDR_W-1:0] preloadAddr;
  logic [15:0]       preloadData;

  always @(posedge clk) begin
    if (preloadEn) padMem[preloadAddr] <= preloadData;
    else if (!sramWeN && sramDqOe) padMem[sramAddr] <= sramDqOut;
  end

  assign sramDqIn = (!sramOeN && !sramDqOe) ? padMem[sramAddr] : 16'h0000;

  // ---------------------------------------------------------------------------
  // Reference model: word storage and the expected load register
  // ---------------------------------------------------------------------------
  bit   [15:0] refMem [0:(1<<ADDR_W)-1];
  logic [31:0] modelRead;

  // SRAM location of the low half of a 32-bit access.
  function automatic logic [17:0] modelLo(input logic [31:0] a);
    logic [31:0] word;
    word = (a - 32'd1024) / 4;
    return 18'((word % 32'h20000) * 2);
  endfunction

  int checks = 0;
  int errors = 0;
  int accIdx = 0;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  // Runs one access that starts in the current idle cycle (the caller is just
  // after a rising edge). It checks every cycle from the request cycle through
  // DONE and returns just after the edge that leaves DONE. Inputs are left
  // unchanged, so the next call follows on with no gap.
  task automatic runAccess(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input bit drop,
                           input logic expWrite, input logic [17:0] expLo,
                           input logic [31:0] expRead);
    logic [3:0]  expCtrl;   // {ready, sramWeN, sramOeN, sramDqOe}
    logic [17:0] expAddr;
    int          j;
    bit          hi;
    accIdx++;
    rdEn = rd; wrEn = wr; address = addr; writeData = wdata;
    for (int k = 0; k <= 2*W+1; k++) begin
      @(negedge clk);
      if (k == 0) begin
        expCtrl = 4'b0110;
      end else if (k == 2*W+1) begin
        expCtrl = 4'b1110;
        check($sformatf("acc%0d done addr", accIdx), 64'(sramAddr), 64'(expLo + 18'd1));
        check($sformatf("acc%0d readData", accIdx), 64'(readData), 64'(expRead));
      end else begin
        j  = (k - 1) % W;
        hi = (k > W);
        expAddr = expLo + 18'(hi);
        check($sformatf("acc%0d k%0d addr", accIdx, k), 64'(sramAddr), 64'(expAddr));
        if (expWrite) begin
          expCtrl = {1'b0, (j == W-1), 1'b1, 1'b1};
          check($sformatf("acc%0d k%0d dq", accIdx, k), 64'(sramDqOut),
                64'(hi ? wdata[31:16] : wdata[15:0]));
        end else begin
          expCtrl = 4'b0100;
        end
      end
      check($sformatf("acc%0d k%0d ctrl", accIdx, k),
            64'({ready, sramWeN, sramOeN, sramDqOe}), 64'(expCtrl));
      @(posedge clk); #1;
      if (drop && k == 0) begin
        rdEn = 1'($urandom); wrEn = 1'($urandom);
        address = $urandom; writeData = $urandom;
      end
    end
  endtask

  task automatic idleCycles(input int n);
    rdEn = 1'b0; wrEn = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("idle ctrl", 64'({ready, sramWeN, sramOeN, sramDqOe}), 64'(4'b1110));
      check("idle readData", 64'(readData), 64'(modelRead));
      @(posedge clk); #1;
    end
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          drop;
    logic        expWrite;
    logic [17:0] expLo;
    logic [31:0] expRead;
  } vecT;

  vecT vecs [NV];

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] ra, rdat, er;
    logic [17:0] lo;
    logic        r, w;
    int          sel;

    //          rd    wr    addr           wdata          drop expW  expLo       expRead
    vecs[0]  = '{1'b1, 1'b0, 32'd1028,     32'h0,         1'b0, 1'b0, 18'd2,      32'hABCD1234};
    vecs[1]  = '{1'b0, 1'b1, 32'd1028,     32'hDEADBEEF,  1'b0, 1'b1, 18'd2,      32'hABCD1234};
    vecs[2]  = '{1'b1, 1'b0, 32'd1028,     32'h0,         1'b0, 1'b0, 18'd2,      32'hDEADBEEF};
    vecs[3]  = '{1'b1, 1'b1, 32'd1032,     32'h55AA33CC,  1'b1, 1'b1, 18'd4,      32'hDEADBEEF};
    vecs[4]  = '{1'b1, 1'b0, 32'd1032,     32'h0,         1'b0, 1'b0, 18'd4,      32'h55AA33CC};
    vecs[5]  = '{1'b0, 1'b1, 32'd1020,     32'h0BADF00D,  1'b0, 1'b1, 18'h3FFFE,  32'h55AA33CC};
    vecs[6]  = '{1'b1, 1'b0, 32'd1020,     32'h0,         1'b1, 1'b0, 18'h3FFFE,  32'h0BADF00D};
    vecs[7]  = '{1'b0, 1'b1, 32'h00100400, 32'h13579BDF,  1'b0, 1'b1, 18'd0,      32'h0BADF00D};
    vecs[8]  = '{1'b1, 1'b0, 32'd1024,     32'h0,         1'b0, 1'b0, 18'd0,      32'h13579BDF};
    vecs[9]  = '{1'b1, 1'b0, 32'd1028,     32'h0,         1'b0, 1'b0, 18'd2,      32'hDEADBEEF};
    vecs[10] = '{1'b1, 1'b0, 32'd1030,     32'h0,         1'b0, 1'b0, 18'd2,      32'hDEADBEEF};

    rst = 1'b0; rdEn = 1'b0; wrEn = 1'b0; address = '0; writeData = '0;
    preloadEn = 1'b0; preloadAddr = '0; preloadData = '0;
    modelRead = '0;
    refMem[2] = 16'h1234;
    refMem[3] = 16'hABCD;

    // Reset values, with the preload loaded while the controller is held in reset.
    @(posedge clk); #1;
    preloadEn = 1'b1; preloadAddr = 18'd2; preloadData = 16'h1234;
    @(posedge clk); #1;
    preloadAddr = 18'd3; preloadData = 16'hABCD;
    @(posedge clk); #1;
    preloadEn = 1'b0;
    @(negedge clk);
    check("reset ctrl", 64'({ready, sramWeN, sramOeN, sramDqOe}), 64'(4'b1110));
    check("reset addr", 64'(sramAddr), 64'(0));
    check("reset dqOut", 64'(sramDqOut), 64'(0));
    check("reset readData", 64'(readData), 64'(0));
    rst = 1'b1;
    @(posedge clk); #1;
    idleCycles(2);

    // Directed table. Rows run back-to-back with no idle gap.
    for (int i = 0; i < NV; i++) begin
      runAccess(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].drop,
                vecs[i].expWrite, vecs[i].expLo, vecs[i].expRead);
      if (vecs[i].expWrite) begin
        refMem[vecs[i].expLo]         = vecs[i].wdata[15:0];
        refMem[vecs[i].expLo + 18'd1] = vecs[i].wdata[31:16];
      end
      modelRead = vecs[i].expRead;
    end
    idleCycles(2);

    // Reset asserted during the high half of a store to word 2000/2001.
    rdEn = 1'b0; wrEn = 1'b1; address = 32'd5024; writeData = 32'hCAFEF00D;
    repeat (W + 2) begin
      @(posedge clk); #1;
    end
    rdEn = 1'b0; wrEn = 1'b0;
    @(negedge clk);
    check("pre-reset high addr", 64'(sramAddr), 64'(18'd2001));
    check("pre-reset weN", 64'(sramWeN), 64'(1'b0));
    #1 rst = 1'b0;
    #1;
    check("async reset ctrl", 64'({ready, sramWeN, sramOeN, sramDqOe}), 64'(4'b1110));
    check("async reset readData", 64'(readData), 64'(0));
    check("async reset addr", 64'(sramAddr), 64'(0));
    modelRead = '0;
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b1;
    idleCycles(2);

    // Store after reset leaves readData at 0; the load after it returns the data.
    runAccess(1'b0, 1'b1, 32'd1036, 32'h11112222, 1'b0, 1'b1, 18'd6, 32'h0);
    refMem[6] = 16'h2222; refMem[7] = 16'h1111;
    runAccess(1'b1, 1'b0, 32'd1036, 32'h0, 1'b0, 1'b0, 18'd6, 32'h11112222);
    modelRead = 32'h11112222;
    runAccess(1'b1, 1'b0, 32'd1028, 32'h0, 1'b1, 1'b0, 18'd2, 32'hDEADBEEF);
    modelRead = 32'hDEADBEEF;
    idleCycles(1);

    // Randomised accesses checked against the reference memory.
    for (int n = 0; n < 40; n++) begin
      sel = int'($urandom_range(1, 3));
      r = sel[0];
      w = sel[1];
      if (w && $urandom_range(0, 7) == 0) ra = $urandom;
      else ra = 32'd1024 + 32'($urandom_range(0, 127));
      rdat = $urandom;
      lo = modelLo(ra);
      er = w ? modelRead : {refMem[lo + 18'd1], refMem[lo]};
      runAccess(r, w, ra, rdat, ($urandom_range(0, 3) == 0), w, lo, er);
      if (w) begin
        refMem[lo]         = rdat[15:0];
        refMem[lo + 18'd1] = rdat[31:16];
      end
      modelRead = er;
      if ($urandom_range(0, 2) == 0) idleCycles(int'($urandom_range(1, 3)));
    end
    idleCycles(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
